// File: rtl/uart_memory_dumper.sv
// Reads a range of 32-bit words from a synchronous memory read port and sends
// them to the PC over an 8N1 UART line, least-significant byte first.
module uart_memory_dumper #(
   parameter int unsigned CLKS_PER_BIT = 781,
   parameter int unsigned ADDR_WIDTH   = 14
) (
   input  logic                  iFpgaClock,
   input  logic                  iFpgaReset,
   input  logic                  iStartDump,
   input  logic [ADDR_WIDTH-1:0] iStartWordAddress,
   input  logic [ADDR_WIDTH:0]   iWordCount,
   output logic [ADDR_WIDTH-1:0] oMemReadAddress,
   input  logic [31:0]           iMemReadData,
   output logic                  oFpgaUartToPc,
   output logic                  oBusy,
   output logic                  oDone
);

   localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
   localparam int unsigned CLK_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       BIT_START = 4'd0;
   localparam logic [3:0]       BIT_LAST_DATA = 4'd8;
   localparam logic [3:0]       BIT_STOP = 4'd9;
   localparam logic [1:0]       BYTE_LAST = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ_ADDR,
      S_READ_DATA,
      S_SEND,
      S_NEXT
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [31:0]           shift_q, shift_d;
   logic [CLK_W-1:0]      clk_cnt_q, clk_cnt_d;
   logic [3:0]            bit_idx_q, bit_idx_d;
   logic [1:0]            byte_idx_q, byte_idx_d;
   logic                  line_q, line_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   // State and datapath registers; reset overrides everything.
   always_ff @(posedge iFpgaClock) begin
      if (iFpgaReset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         count_q    <= '0;
         shift_q    <= '0;
         clk_cnt_q  <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         line_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         shift_q    <= shift_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         line_q     <= line_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      count_d    = count_q;
      shift_d    = shift_q;
      clk_cnt_d  = clk_cnt_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      line_d     = line_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // A start coinciding with the completion pulse is dropped.
            if (iStartDump && !done_q) begin
               if (iWordCount == '0) begin
                  done_d = 1'b1;
               end else begin
                  addr_d  = iStartWordAddress;
                  count_d = iWordCount;
                  busy_d  = 1'b1;
                  state_d = S_READ_ADDR;
               end
            end
         end

         S_READ_ADDR: begin
            state_d = S_READ_DATA;
         end

         S_READ_DATA: begin
            shift_d    = iMemReadData;
            line_d     = 1'b0;
            clk_cnt_d  = '0;
            bit_idx_d  = BIT_START;
            byte_idx_d = '0;
            state_d    = S_SEND;
         end

         S_SEND: begin
            if (clk_cnt_q == CLK_LAST) begin
               clk_cnt_d = '0;
               if (bit_idx_q == BIT_STOP) begin
                  bit_idx_d = BIT_START;
                  if (byte_idx_q == BYTE_LAST) begin
                     byte_idx_d = '0;
                     line_d     = 1'b1;
                     state_d    = S_NEXT;
                  end else begin
                     byte_idx_d = byte_idx_q + 2'd1;
                     line_d     = 1'b0;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
                  // shift_q[0] always holds the data bit being sent next or now.
                  if (bit_idx_q == BIT_START) begin
                     line_d = shift_q[0];
                  end else if (bit_idx_q == BIT_LAST_DATA) begin
                     line_d  = 1'b1;
                     shift_d = {1'b0, shift_q[31:1]};
                  end else begin
                     line_d  = shift_q[1];
                     shift_d = {1'b0, shift_q[31:1]};
                  end
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CLK_W'(1);
            end
         end

         S_NEXT: begin
            count_d = count_q - CNT_W'(1);
            addr_d  = addr_q + ADDR_WIDTH'(1);
            if (count_q == CNT_W'(1)) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_READ_ADDR;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign oMemReadAddress = addr_q;
   assign oFpgaUartToPc   = line_q;
   assign oBusy           = busy_q;
   assign oDone           = done_q;

endmodule

// File: tb/tb_uart_memory_dumper.sv
// Directed bench for uart_memory_dumper: decodes the UART line and checks
// bytes, frame timing, busy/done pulses and read addresses.
module tb_uart_memory_dumper;

   localparam int unsigned CPB    = 4;
   localparam int unsigned ADDR_W = 14;

   logic              clk;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W:0]   word_count;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_rdata;
   logic              uart_line;
   logic              busy;
   logic              done;

   uart_memory_dumper #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(ADDR_W)) dut (
      .iFpgaClock       (clk),
      .iFpgaReset       (rst),
      .iStartDump       (start),
      .iStartWordAddress(start_addr),
      .iWordCount       (word_count),
      .oMemReadAddress  (mem_addr),
      .iMemReadData     (mem_rdata),
      .oFpgaUartToPc    (uart_line),
      .oBusy            (busy),
      .oDone            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
      if (a == ADDR_W'(5)) return 32'h1234_5678;
      return 32'h1000_0000 + 32'(a);
   endfunction

   // Synchronous BRAM: data valid one cycle after the address.
   always @(posedge clk) mem_rdata <= mem_word(mem_addr);

   // Line / status monitor, sampled on the falling edge.
   logic [7:0] byte_log[$];
   int         fstart_log[$];
   int         done_log[$];
   int         rise_log[$];
   int         fall_log[$];
   int         low_cnt   = 0;
   int         frame_err = 0;
   bit         rx_act    = 0;
   int         rx_ph     = 0;
   logic [7:0] rx_byte   = '0;
   bit         busy_prev = 0;

   always @(negedge clk) begin
      if (rst) begin
         rx_act    = 0;
         busy_prev = 0;
      end else begin
         if (done) done_log.push_back(cyc);
         if (busy && !busy_prev) rise_log.push_back(cyc);
         if (!busy && busy_prev) fall_log.push_back(cyc);
         busy_prev = busy;
         if (!uart_line) low_cnt++;
         if (!rx_act) begin
            if (!uart_line) begin
               rx_act = 1;
               rx_ph  = 0;
               fstart_log.push_back(cyc);
            end
         end else begin
            rx_ph++;
         end
         if (rx_act && (rx_ph % CPB) == CPB / 2) begin
            int k;
            k = rx_ph / CPB;
            if (k == 0) begin
               if (uart_line) frame_err++;
            end else if (k <= 8) begin
               rx_byte[k-1] = uart_line;
            end else begin
               if (!uart_line) frame_err++;
               byte_log.push_back(rx_byte);
               rx_act = 0;
            end
         end
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int byte_at(input int i);
      if (i < byte_log.size()) return int'(byte_log[i]);
      return -1;
   endfunction

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   task automatic goto_cycle(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_dump(input int a, input int c, output int x);
      start_addr = ADDR_W'(a);
      word_count = (ADDR_W + 1)'(c);
      start      = 1'b1;
      x          = cyc;
      goto_cycle(cyc + 1);
      start      = 1'b0;
      start_addr = 14'h1555;
      word_count = 15'd7;
   endtask

   task automatic check_word(input string tag, input int idx, input logic [31:0] w);
      for (int i = 0; i < 4; i++)
         check($sformatf("%s_b%0d", tag, i), byte_at(idx + i), int'((w >> (8 * i)) & 32'hFF));
   endtask

   initial begin
      int x, y, b, d, r, f, fl, lc, a0;
      rst        = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      word_count = '0;

      goto_cycle(3);
      @(negedge clk);
      check("rst_line", int'(uart_line), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_addr", int'(mem_addr), 0);
      goto_cycle(4);
      rst = 1'b0;

      // Single word
      goto_cycle(6);
      b = byte_log.size(); d = done_log.size(); r = rise_log.size();
      f = fstart_log.size(); fl = fall_log.size();
      start_dump(5, 1, x);
      @(negedge clk);
      check("single_addr", int'(mem_addr), 5);
      goto_cycle(x + 200);
      check("single_nbytes", byte_log.size() - b, 4);
      check_word("single", b, 32'h1234_5678);
      check("single_start_bit", qget(fstart_log, f) - x, 3);
      check("single_ndone", done_log.size() - d, 1);
      check("single_done_at", qget(done_log, d) - x, 164);
      check("single_busy_rise", qget(rise_log, r) - x, 1);
      check("single_busy_fall", qget(fall_log, fl) - x, 164);

      // Zero count
      goto_cycle(cyc + 2);
      a0 = int'(mem_addr); lc = low_cnt; d = done_log.size(); r = rise_log.size();
      start_dump(7, 0, x);
      @(negedge clk);
      check("zero_done_pulse", int'(done), 1);
      goto_cycle(x + 30);
      check("zero_ndone", done_log.size() - d, 1);
      check("zero_done_at", qget(done_log, d) - x, 1);
      check("zero_busy", rise_log.size() - r, 0);
      check("zero_line_low", low_cnt - lc, 0);
      check("zero_addr", int'(mem_addr), a0);

      // Address wrap-around
      b = byte_log.size(); d = done_log.size(); f = fstart_log.size();
      start_dump(14'h3FFF, 2, x);
      @(negedge clk);
      check("wrap_addr0", int'(mem_addr), 14'h3FFF);
      goto_cycle(x + 164);
      @(negedge clk);
      check("wrap_addr1", int'(mem_addr), 0);
      goto_cycle(x + 340);
      check("wrap_nbytes", byte_log.size() - b, 8);
      check_word("wrap_w0", b, 32'h1000_3FFF);
      check_word("wrap_w1", b + 4, 32'h1000_0000);
      check("wrap_gap", qget(fstart_log, f + 4) - (qget(fstart_log, f + 3) + 10 * CPB), 3);
      check("wrap_word_period", qget(fstart_log, f + 4) - qget(fstart_log, f), 163);
      check("wrap_done_at", qget(done_log, d) - x, 327);

      // Ignored restarts: mid-dump and on the done cycle
      b = byte_log.size(); d = done_log.size(); r = rise_log.size();
      start_dump(5, 1, x);
      goto_cycle(x + 50);
      start_addr = 14'd9; word_count = 15'd1; start = 1'b1;
      goto_cycle(x + 51);
      start = 1'b0;
      goto_cycle(x + 164);
      start_addr = 14'd9; word_count = 15'd1; start = 1'b1;
      @(negedge clk);
      check("ign_done_pulse", int'(done), 1);
      goto_cycle(x + 165);
      start = 1'b0;
      goto_cycle(x + 400);
      check("ign_nbytes", byte_log.size() - b, 4);
      check_word("ign", b, 32'h1234_5678);
      check("ign_ndone", done_log.size() - d, 1);
      check("ign_nbusy", rise_log.size() - r, 1);

      // Reset during data bit 3 of byte 1
      b = byte_log.size(); d = done_log.size();
      start_dump(5, 1, x);
      goto_cycle(x + 60);
      rst = 1'b1;
      goto_cycle(x + 61);
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_line", int'(uart_line), 1);
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_done", int'(done), 0);
      goto_cycle(x + 250);
      check("rst_mid_ndone", done_log.size() - d, 0);
      check("rst_mid_nbytes", byte_log.size() - b, 1);
      b = byte_log.size(); d = done_log.size();
      start_dump(2, 1, x);
      goto_cycle(x + 200);
      check("after_rst_nbytes", byte_log.size() - b, 4);
      check_word("after_rst", b, 32'h1000_0002);
      check("after_rst_done_at", qget(done_log, d) - x, 164);

      // Back-to-back dumps
      b = byte_log.size(); d = done_log.size();
      start_dump(14'h10, 3, x);
      goto_cycle(x + 490);
      @(negedge clk);
      check("b2b_done1", int'(done), 1);
      goto_cycle(x + 491);
      start_dump(14'h20, 1, y);
      goto_cycle(y + 200);
      check("b2b_nbytes", byte_log.size() - b, 16);
      check_word("b2b_w0", b, 32'h1000_0010);
      check_word("b2b_w1", b + 4, 32'h1000_0011);
      check_word("b2b_w2", b + 8, 32'h1000_0012);
      check_word("b2b_w3", b + 12, 32'h1000_0020);
      check("b2b_ndone", done_log.size() - d, 2);
      check("b2b_done_at0", qget(done_log, d) - x, 490);
      check("b2b_done_at1", qget(done_log, d + 1) - y, 164);

      check("framing_errors", frame_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_memory_dumper.md
Name: uart_memory_dumper

Overview:
- Transmit-side counterpart of the UART programmer path. On request, it reads a range of 32-bit words from a memory read port and serialises them to the PC over UART, 8N1.
- Sits beside the programmer inside the memory wrapper on the FPGA clock domain. It gives the PC a readback of instruction or data memory so images loaded from .coe files can be verified.
- The caller muxes the memory read port, so this block assumes exclusive use of the port while oBusy=1.

Parameters:
CLKS_PER_BIT, 781, iFpgaClock cycles per UART bit (100 MHz / 128000 baud); legal range >= 2.
ADDR_WIDTH, 14, word-address width of the memory read port.

Ports:
iFpgaClock  input  1  system clock; all logic on rising edge.
iFpgaReset  input  1  reset, synchronous, active-high.
iStartDump  input  1  start request; sampled only in IDLE.
iStartWordAddress  input  ADDR_WIDTH  first word address; latched on accepted start.
iWordCount  input  ADDR_WIDTH+1  number of words to send; latched on accepted start; 0 is legal.
oMemReadAddress  output  ADDR_WIDTH  word address to the memory read port.
iMemReadData  input  32  read data; valid exactly 1 cycle after oMemReadAddress is presented (synchronous BRAM).
oFpgaUartToPc  output  1  UART TX line; idle high.
oBusy  output  1  high from the cycle after an accepted start until the dump ends.
oDone  output  1  one-cycle pulse when a dump completes normally.

Behaviour:
- Reset values, held while iFpgaReset=1: state IDLE, oFpgaUartToPc=1, oBusy=0, oDone=0, oMemReadAddress=0, all counters 0. Reset wins over every other input in the same cycle.
- States: IDLE, READ_ADDR, READ_DATA, SEND, NEXT.
- IDLE:
  - iStartDump=1 at edge N latches the address and count.
  - If count=0: go to IDLE with oDone=1 for the cycle after N; oBusy stays 0; the line stays high.
  - Otherwise: go to READ_ADDR; oBusy=1 from cycle N+1.
- READ_ADDR (1 cycle): oMemReadAddress = current address.
- READ_DATA (1 cycle): iMemReadData is latched into a 32-bit shift word at the end of this cycle.
- SEND:
  - Transmits 4 bytes, least-significant byte first (bits [7:0], [15:8], [23:16], [31:24]). This matches the programmer's byte order.
  - Each byte is a start bit (0), 8 data bits LSB first, and a stop bit (1). Every bit holds exactly CLKS_PER_BIT cycles.
  - The start bit of byte 0 appears on oFpgaUartToPc in cycle N+3 for the first word.
  - No idle gap between bytes of one word.
- NEXT (1 cycle, line high):
  - Decrement the remaining count.
  - Increment the address modulo 2^ADDR_WIDTH (0x3FFF+1 = 0x0000).
  - If remaining was 1: go to IDLE, oBusy=0 and oDone=1 in the same following cycle.
  - Otherwise: go to READ_ADDR.
  - Inter-word gap is 3 cycles of line-high after the stop bit: NEXT, READ_ADDR, READ_DATA.
- Frame length per word: 40*CLKS_PER_BIT cycles. Total dump length for count W >= 1: 1 + W*(2 + 40*CLKS_PER_BIT + 1) cycles from the accept edge to oDone.
- iStartDump while oBusy=1 is ignored; it is not queued. iStartDump in the same cycle as oDone is also ignored. A new start is accepted from the cycle after the oDone pulse.
- Start and address inputs may change freely after acceptance; only the latched copies are used.
- Reset mid-operation (any state, including mid-bit): next cycle line=1, oBusy=0, oDone=0, state IDLE. The partial frame is abandoned and no completion is reported.
- oFpgaUartToPc is driven from a register; no combinational glitches.
- The bit counter and byte counter must wrap cleanly; no extra or short bits at byte boundaries.

Test Plan:
Use CLKS_PER_BIT=4 and memory model mem[a]=0x1000_0000+a unless stated.
- Single word: mem[5]=0x12345678; start addr=5, count=1.
  - Line decodes bytes 0x78, 0x56, 0x34, 0x12.
  - Start bit at N+3; each bit 4 cycles.
  - oDone at cycle N+164; oBusy high N+1..N+163.
- Zero count: start addr=7, count=0 -> oDone pulse at N+1, oBusy never high, line never low, oMemReadAddress unchanged.
- Wrap-around: addr=0x3FFF, count=2.
  - oMemReadAddress is 0x3FFF then 0x0000.
  - Bytes 0xFF,0x3F,0x00,0x10 then 0x00,0x00,0x00,0x10.
  - Exactly 3 idle-high cycles between the two frames.
- Ignored restart: pulse iStartDump with addr=9 midway through the count=1 dump of addr=5 -> only the addr=5 word is sent; one oDone. A start on the oDone cycle is also ignored.
- Reset mid-byte: assert iFpgaReset during data bit 3 of byte 1 -> next cycle line=1, oBusy=0; no oDone. A fresh start of addr=2, count=1 afterwards sends 0x02,0x00,0x00,0x10 correctly.
- Back-to-back: start count=3 at addr=0x10, then restart the cycle after oDone with addr=0x20, count=1 -> 4 frames total, correct data and addresses, two oDone pulses.
